// File: rtl/power_integrate_pkg.sv
// Shared types and constants for the power integrator sequencer: FSM state
// encoding, integrator settings-register offsets and integrator field widths.
package power_integrate_pkg;

  localparam int POWER_W    = 32;
  localparam int INTEG_W    = 16;
  localparam int SCALE_W    = 4;
  localparam int SET_ADDR_W = 8;
  localparam int SET_DATA_W = 32;

  localparam int SR_SCALE     = 0;
  localparam int SR_INTEGRATE = 1;
  localparam int SR_ENABLE    = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG_SCALE = 3'd1,
    ST_CFG_INT   = 3'd2,
    ST_CFG_EN    = 3'd3,
    ST_RUN       = 3'd4,
    ST_DISABLE   = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // Integration length register value: 2^log2_n in the low INTEG_W bits.
  function automatic logic [SET_DATA_W-1:0] integ_len(input logic [SCALE_W-1:0] l2);
    logic [INTEG_W-1:0] len;
    len = INTEG_W'(1) << l2;
    return {{(SET_DATA_W-INTEG_W){1'b0}}, len};
  endfunction

endpackage

// File: rtl/power_integrate_seq_if.sv
// Link between the sequencer and one power integrator: settings bus, run
// control, and the integrator's result/strobe back to the sequencer.
interface power_integrate_seq_if;
  import power_integrate_pkg::*;

  logic                  set_stb;
  logic [SET_ADDR_W-1:0] set_addr;
  logic [SET_DATA_W-1:0] set_data;
  logic                  run;
  logic [POWER_W-1:0]    power_in;
  logic                  strobe_in;

  modport master (output set_stb, set_addr, set_data, run,
                  input  power_in, strobe_in);
  modport slave  (input  set_stb, set_addr, set_data, run,
                  output power_in, strobe_in);
endinterface

// File: rtl/power_peak_hold.sv
// Per-sequence result tracking: last and peak (unsigned) integrator power
// and the number of results collected; cleared at the start of a sequence.
module power_peak_hold
  import power_integrate_pkg::*;
#(
  parameter int DUMP_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               update,
  input  logic [POWER_W-1:0] power,
  output logic [DUMP_W-1:0]  dump_count,
  output logic [POWER_W-1:0] peak,
  output logic [POWER_W-1:0] last
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dump_count <= '0;
      peak       <= '0;
      last       <= '0;
    end else if (clear) begin
      dump_count <= '0;
      peak       <= '0;
      last       <= '0;
    end else if (update) begin
      dump_count <= dump_count + DUMP_W'(1);
      last       <= power;
      if (power > peak) peak <= power;
    end
  end

endmodule

// File: rtl/power_integrate_seq.sv
// Power integrator sequencer: programs scale/length/enable, runs for a number
// of dumps, tracks peak/last, tears down. Optional watchdog: POWER_INTEGRATE_SEQ_TIMEOUT_EN.
module power_integrate_seq
  import power_integrate_pkg::*;
#(
  parameter int BASE           = 0,
  parameter int DUMP_W         = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SCALE_W-1:0]   log2_n,
  input  logic [DUMP_W-1:0]    num_dumps,
  power_integrate_seq_if.master intg,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 timeout,
  output logic [DUMP_W-1:0]    dump_count,
  output logic [POWER_W-1:0]   peak,
  output logic [POWER_W-1:0]   last
);

  localparam logic [SET_ADDR_W-1:0] ADDR_SCALE = SET_ADDR_W'(BASE + SR_SCALE);
  localparam logic [SET_ADDR_W-1:0] ADDR_INT   = SET_ADDR_W'(BASE + SR_INTEGRATE);
  localparam logic [SET_ADDR_W-1:0] ADDR_EN    = SET_ADDR_W'(BASE + SR_ENABLE);

  state_t              state, nxt;
  logic [SCALE_W-1:0]  log2_q;
  logic [DUMP_W-1:0]   num_q;
  logic                clear, update, last_dump, expire, teardown;

  assign clear     = (state == ST_IDLE) && start;
  assign update    = (state == ST_RUN) && intg.strobe_in;
  assign last_dump = update && ((dump_count + DUMP_W'(1)) == num_q);
  assign teardown  = (state inside {ST_CFG_SCALE, ST_CFG_INT, ST_CFG_EN, ST_RUN}) &&
                     (abort || expire);

  always_ff @(posedge clk) begin
    if (clear) begin
      log2_q <= log2_n;
      num_q  <= num_dumps;
    end
  end

`ifdef POWER_INTEGRATE_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;

  // Held at zero outside RUN, so it starts from zero on RUN entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                wd <= '0;
    else if (state != ST_RUN || intg.strobe_in) wd <= '0;
    else                                         wd <= wd + WD_W'(1);
  end

  assign expire = (state == ST_RUN) && !intg.strobe_in &&
                  (wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    timeout <= 1'b0;
    else if (clear)  timeout <= 1'b0;
    else if (expire) timeout <= 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:      if (start) nxt = ST_CFG_SCALE;
      ST_CFG_SCALE: nxt = abort ? ST_DISABLE : ST_CFG_INT;
      ST_CFG_INT:   nxt = abort ? ST_DISABLE : ST_CFG_EN;
      ST_CFG_EN:    nxt = (abort || num_q == '0) ? ST_DISABLE : ST_RUN;
      ST_RUN:       if (abort || last_dump || expire) nxt = ST_DISABLE;
      ST_DISABLE:   nxt = ST_DONE;
      ST_DONE:      nxt = ST_IDLE;
      default:      nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      intg.run      <= 1'b0;
      intg.set_stb  <= 1'b0;
      intg.set_addr <= '0;
      intg.set_data <= '0;
    end else begin
      state        <= nxt;
      busy         <= (nxt != ST_IDLE);
      done         <= (nxt == ST_DONE);
      intg.run     <= (nxt == ST_RUN);
      intg.set_stb <= (nxt inside {ST_CFG_SCALE, ST_CFG_INT, ST_CFG_EN, ST_DISABLE});
      if (clear)         aborted <= 1'b0;
      else if (teardown) aborted <= 1'b1;
      unique case (nxt)
        ST_CFG_SCALE: begin
          intg.set_addr <= ADDR_SCALE;
          intg.set_data <= {{(SET_DATA_W-SCALE_W){1'b0}}, log2_n};
        end
        ST_CFG_INT: begin
          intg.set_addr <= ADDR_INT;
          intg.set_data <= integ_len(log2_q);
        end
        ST_CFG_EN: begin
          intg.set_addr <= ADDR_EN;
          intg.set_data <= SET_DATA_W'(1);
        end
        ST_DISABLE: begin
          intg.set_addr <= ADDR_EN;
          intg.set_data <= '0;
        end
        default: ;
      endcase
    end
  end

  power_peak_hold #(.DUMP_W(DUMP_W)) u_peak_hold (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .update     (update),
    .power      (intg.power_in),
    .dump_count (dump_count),
    .peak       (peak),
    .last       (last)
  );

endmodule

// File: tb/tb_power_integrate_seq.sv
// Bench for power_integrate_seq: settings writes go through a scoreboard queue,
// per-scenario tasks check timing, results and teardown.
module tb_power_integrate_seq;
  import power_integrate_pkg::*;

  localparam int BASE   = 16;
  localparam int DUMP_W = 8;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [3:0]        log2_n = '0;
  logic [DUMP_W-1:0] num_dumps = '0;
  logic              busy, done, aborted, timeout;
  logic [DUMP_W-1:0] dump_count;
  logic [31:0]       peak, last;

  power_integrate_seq_if intf ();

  power_integrate_seq #(.BASE(BASE), .DUMP_W(DUMP_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .log2_n(log2_n), .num_dumps(num_dumps), .intg(intf),
    .busy(busy), .done(done), .aborted(aborted), .timeout(timeout),
    .dump_count(dump_count), .peak(peak), .last(last)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_wr[$];
  wr_t mon_w;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  run_seen = 1'b0;

  // Scoreboard: every settings strobe must match the next queued write.
  always @(negedge clk) begin
    if (intf.run) run_seen = 1'b1;
    if (intf.set_stb) begin
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_bad++;
        $display("FAIL set_write: got addr=%0d data=%0d, required no write", intf.set_addr, intf.set_data);
      end else begin
        mon_w = exp_wr.pop_front();
        if (intf.set_addr !== mon_w.addr || intf.set_data !== mon_w.data) begin
          n_bad++;
          $display("FAIL set_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   intf.set_addr, intf.set_data, mon_w.addr, mon_w.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = 8'(a);
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_seq(input logic [3:0] l2, input bit with_disable);
    push_wr(BASE + 0, {28'b0, l2});
    push_wr(BASE + 1, 32'(1) << l2);
    push_wr(BASE + 2, 32'd1);
    if (with_disable) push_wr(BASE + 2, 32'd0);
  endtask

  task automatic kick(input logic [3:0] l2, input logic [DUMP_W-1:0] nd);
    log2_n = l2; num_dumps = nd; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] p);
    intf.power_in = p; intf.strobe_in = 1'b1;
    tick();
    intf.strobe_in = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if ({busy, done, aborted, timeout, intf.run, intf.set_stb} !== 6'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b, required 000000", {busy, done, aborted, timeout, intf.run, intf.set_stb}); end
    n_cmp++; if ({dump_count, peak, last} !== '0) begin n_bad++; $display("FAIL reset_data: got cnt=%0d peak=%0d last=%0d, required 0", dump_count, peak, last); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    push_seq(4'd4, 1'b1);
    kick(4'd4, 8'd3);
    n_cmp++; if ({intf.set_stb, intf.run, busy} !== 3'b101) begin n_bad++; $display("FAIL basic_c1: got stb/run/busy=%b, required 101", {intf.set_stb, intf.run, busy}); end
    tick();
    n_cmp++; if (intf.set_stb !== 1'b1) begin n_bad++; $display("FAIL basic_c2_stb: got %b, required 1", intf.set_stb); end
    tick();
    n_cmp++; if ({intf.set_stb, intf.run} !== 2'b10) begin n_bad++; $display("FAIL basic_c3: got stb/run=%b, required 10", {intf.set_stb, intf.run}); end
    tick();
    n_cmp++; if ({intf.set_stb, intf.run} !== 2'b01) begin n_bad++; $display("FAIL basic_c4: got stb/run=%b, required 01", {intf.set_stb, intf.run}); end
    strobe(32'd10);
    tick();
    strobe(32'd50);
    strobe(32'd20);
    n_cmp++; if ({intf.run, intf.set_stb, done} !== 3'b010) begin n_bad++; $display("FAIL basic_disable: got run/stb/done=%b, required 010", {intf.run, intf.set_stb, done}); end
    tick();
    n_cmp++; if ({done, busy, intf.set_stb} !== 3'b110) begin n_bad++; $display("FAIL basic_done: got done/busy/stb=%b, required 110", {done, busy, intf.set_stb}); end
    tick();
    n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL basic_idle: got done/busy=%b, required 00", {done, busy}); end
    n_cmp++; if (peak !== 32'd50 || last !== 32'd20 || dump_count !== 8'd3 || aborted !== 1'b0) begin n_bad++; $display("FAIL basic_results: got peak=%0d last=%0d cnt=%0d ab=%b, required 50 20 3 0", peak, last, dump_count, aborted); end
    n_cmp++; if (exp_wr.size() != 0) begin n_bad++; $display("FAIL basic_writes: got %0d pending, required 0", exp_wr.size()); end
  endtask

  task automatic test_zero_dumps();
    run_seen = 1'b0;
    push_seq(4'd0, 1'b1);
    kick(4'd0, 8'd0);
    n_cmp++; if (peak !== 32'd0 || dump_count !== 8'd0) begin n_bad++; $display("FAIL zero_clear: got peak=%0d cnt=%0d, required 0 0", peak, dump_count); end
    repeat (3) tick();
    n_cmp++; if ({intf.run, intf.set_stb} !== 2'b01) begin n_bad++; $display("FAIL zero_disable: got run/stb=%b, required 01", {intf.run, intf.set_stb}); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b, required 1", done); end
    tick();
    n_cmp++; if ({done, busy, run_seen} !== 3'b000) begin n_bad++; $display("FAIL zero_end: got done/busy/run_seen=%b, required 000", {done, busy, run_seen}); end
    n_cmp++; if (exp_wr.size() != 0) begin n_bad++; $display("FAIL zero_writes: got %0d pending, required 0", exp_wr.size()); end
  endtask

  task automatic test_abort();
    push_seq(4'd2, 1'b1);
    kick(4'd2, 8'd5);
    repeat (3) tick();
    strobe(32'd7);
    strobe(32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if ({intf.run, intf.set_stb, aborted} !== 3'b011) begin n_bad++; $display("FAIL abort_teardown: got run/stb/aborted=%b, required 011", {intf.run, intf.set_stb, aborted}); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL abort_done: got %b, required 1", done); end
    tick();
    n_cmp++; if ({busy, aborted} !== 2'b01 || dump_count !== 8'd2 || peak !== 32'd7 || last !== 32'd3) begin n_bad++; $display("FAIL abort_results: got busy=%b ab=%b cnt=%0d peak=%0d last=%0d, required 0 1 2 7 3", busy, aborted, dump_count, peak, last); end
  endtask

  task automatic test_ignored_inputs();
    strobe(32'd999);
    n_cmp++; if (dump_count !== 8'd2 || last !== 32'd3 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_strobe: got cnt=%0d last=%0d busy=%b, required 2 3 0", dump_count, last, busy); end
    push_seq(4'd3, 1'b1);
    kick(4'd3, 8'd2);
    n_cmp++; if (aborted !== 1'b0 || dump_count !== 8'd0) begin n_bad++; $display("FAIL restart_clear: got ab=%b cnt=%0d, required 0 0", aborted, dump_count); end
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if ({intf.run, intf.set_stb, busy} !== 3'b101 || dump_count !== 8'd0) begin n_bad++; $display("FAIL run_start: got run/stb/busy=%b cnt=%0d, required 101 0", {intf.run, intf.set_stb, busy}, dump_count); end
    strobe(32'h8000_0005);
    strobe(32'd4);
    n_cmp++; if (intf.run !== 1'b0) begin n_bad++; $display("FAIL ign_stop: got run=%b, required 0", intf.run); end
    repeat (2) tick();
    n_cmp++; if (peak !== 32'h8000_0005 || last !== 32'd4 || dump_count !== 8'd2) begin n_bad++; $display("FAIL unsigned_peak: got peak=%0h last=%0d cnt=%0d, required 80000005 4 2", peak, last, dump_count); end
  endtask

  task automatic test_async_reset();
    push_seq(4'd1, 1'b0);
    kick(4'd1, 8'd4);
    repeat (3) tick();
    strobe(32'd77);
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({intf.run, busy, intf.set_stb} !== 3'b000 || peak !== 32'd0) begin n_bad++; $display("FAIL async_reset: got run/busy/stb=%b peak=%0d, required 000 0", {intf.run, busy, intf.set_stb}, peak); end
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    strobe(32'd9);
    tick();
    n_cmp++; if (busy !== 1'b0 || dump_count !== 8'd0 || exp_wr.size() != 0) begin n_bad++; $display("FAIL reset_idle: got busy=%b cnt=%0d pending=%0d, required 0 0 0", busy, dump_count, exp_wr.size()); end
  endtask

  task automatic test_timeout();
    push_seq(4'd0, 1'b1);
    kick(4'd0, 8'd2);
    repeat (3) tick();
`ifdef POWER_INTEGRATE_SEQ_TIMEOUT_EN
    repeat (TMO - 1) tick();
    n_cmp++; if ({intf.run, timeout} !== 2'b10) begin n_bad++; $display("FAIL wd_early: got run/timeout=%b, required 10", {intf.run, timeout}); end
    tick();
    n_cmp++; if ({intf.run, intf.set_stb, timeout, aborted} !== 4'b0111) begin n_bad++; $display("FAIL wd_expire: got run/stb/to/ab=%b, required 0111", {intf.run, intf.set_stb, timeout, aborted}); end
`else
    repeat (150) tick();
    n_cmp++; if ({intf.run, timeout} !== 2'b10) begin n_bad++; $display("FAIL no_wd: got run/timeout=%b, required 10", {intf.run, timeout}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if ({intf.run, intf.set_stb, timeout, aborted} !== 4'b0101) begin n_bad++; $display("FAIL no_wd_abort: got run/stb/to/ab=%b, required 0101", {intf.run, intf.set_stb, timeout, aborted}); end
`endif
    tick();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL wd_done: got %b, required 1", done); end
    tick();
    n_cmp++; if (busy !== 1'b0 || exp_wr.size() != 0) begin n_bad++; $display("FAIL wd_end: got busy=%b pending=%0d, required 0 0", busy, exp_wr.size()); end
  endtask

  initial begin
    intf.power_in = '0;
    intf.strobe_in = 1'b0;
    test_reset();
    test_basic();
    test_zero_dumps();
    test_abort();
    test_ignored_inputs();
    test_async_reset();
    test_timeout();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finished", $time);
    $fatal(1);
  end

endmodule
